// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - digit-serial adder/subtractor with registered carry
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  logic             last_digit;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] sum_dig;
  logic [DIGIT:0]   chain;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  assign last_digit = (cnt == CW'(N - 1));

  // Ripple the current digit through DIGIT full-adder cells and merge it into the result slot.
  always_comb begin
    a_dig    = a_reg[cnt*DIGIT +: DIGIT];
    b_dig    = b_reg[cnt*DIGIT +: DIGIT];
    sum_dig  = '0;
    chain    = '0;
    chain[0] = carry_reg;
    for (int i = 0; i < DIGIT; i++) begin
      {chain[i+1], sum_dig[i]} = full_add(a_dig[i], b_dig[i], chain[i]);
    end
    res_next = res_reg;
    res_next[cnt*DIGIT +: DIGIT] = sum_dig;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_digit) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, digit-by-digit accumulation and result publication on the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= cin ^ sub;
            cnt       <= '0;
          end
        end
        RUN: begin
          res_reg   <= res_next;
          carry_reg <= chain[DIGIT];
          if (last_digit) begin
            cnt  <= '0;
            s    <= res_next;
            cout <= chain[DIGIT];
            ovf  <= chain[DIGIT-1] ^ chain[DIGIT];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - scoreboard testbench for serial_add_sub
module tb_serial_add_sub;

  logic clk;
  int   errors;
  int   checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare helper: every call is one counted check.
  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: integer arithmetic on unsigned and signed views of the operands.
  // Returns {ovf, cout, s[15:0]} with s reduced modulo 2^w.
  function automatic logic [17:0] model(input int w, input longint ua, input longint ub,
                                        input bit c, input bit sbt);
    longint modv;
    longint half;
    longint sa;
    longint sb;
    longint u;
    longint sr;
    bit     co;
    bit     ov;
    modv = longint'(1) << w;
    half = longint'(1) << (w - 1);
    sa   = (ua >= half) ? ua - modv : ua;
    sb   = (ub >= half) ? ub - modv : ub;
    if (!sbt) begin
      u  = ua + ub + longint'(c);
      co = (u >= modv);
      sr = sa + sb + longint'(c);
    end else begin
      u  = ua - ub - longint'(c);
      co = (u >= 0);
      sr = sa - sb - longint'(c);
    end
    u  = ((u % modv) + modv) % modv;
    ov = (sr < -half) || (sr >= half);
    return {ov, co, 16'(u)};
  endfunction

  // ---------------- directed instance: WIDTH=8, DIGIT=1 ----------------
  logic       rst0, iv0, ir0, cin0, sub0, ov0, or0, co0, of0;
  logic [7:0] a0, b0, s0;
  logic [9:0] q0[$];

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_dut0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .cin(cin0), .sub(sub0), .out_valid(ov0), .out_ready(or0), .s(s0),
    .cout(co0), .ovf(of0)
  );

  always @(negedge clk) begin
    if (!rst0) begin
      if (ov0 && ir0) chk("d0_ready_valid_overlap", 1, 0);
      if (ov0 && or0) begin
        if (q0.size() == 0) begin
          chk("d0_unexpected_result", 1, 0);
        end else begin
          logic [9:0] e;
          e = q0.pop_front();
          chk("d0_s", s0, e[7:0]);
          chk("d0_cout", co0, e[8]);
          chk("d0_ovf", of0, e[9]);
        end
      end
    end
  end

  task automatic issue0(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic ts, input logic [7:0] es, input logic ec,
                        input logic eo, input bit noise);
    int w;
    int lat;
    w = 0;
    while (!ir0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("d0_ready_wait", ir0, 1);
    iv0 = 1'b1; a0 = ta; b0 = tb; cin0 = tc; sub0 = ts;
    @(posedge clk); #1;
    q0.push_back({eo, ec, es});
    a0 = 8'($urandom); b0 = 8'($urandom); cin0 = 1'($urandom); sub0 = 1'($urandom);
    iv0 = noise;
    lat = 0;
    while (!ov0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) iv0 = 1'b0;
    end
    iv0 = 1'b0;
    chk("d0_latency", lat, 8);
    if (or0) begin
      @(posedge clk); #1;
      chk("d0_hold_one_cycle", {ov0, ir0}, 2'b01);
    end
  endtask

  // ---------------- randomized instances ----------------
  logic rst_r;

  for (genvar g = 0; g < 5; g++) begin : g_cfg
    localparam int W    = (g == 4) ? 8 : 16;
    localparam int D    = (g == 4) ? 4 : (1 << g);
    localparam int N    = W / D;
    localparam int NOPS = (g == 4) ? 200 : 1000;

    logic         iv, ir, ci, sb, ov, ordy, gc, go;
    logic [W-1:0] ga, gb, gs;
    logic [W+1:0] q[$];
    bit           done_g;

    serial_add_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .rst(rst_r), .in_valid(iv), .in_ready(ir), .a(ga), .b(gb),
      .cin(ci), .sub(sb), .out_valid(ov), .out_ready(ordy), .s(gs),
      .cout(gc), .ovf(go)
    );

    initial begin
      ordy = 1'b0;
      forever begin
        @(posedge clk); #1;
        ordy = ($urandom_range(0, 3) != 0);
      end
    end

    always @(negedge clk) begin
      if (!rst_r && ov && ordy) begin
        if (q.size() == 0) begin
          chk($sformatf("g%0d_unexpected_result", g), 1, 0);
        end else begin
          logic [W+1:0] e;
          e = q.pop_front();
          chk($sformatf("g%0d_s", g), gs, e[W-1:0]);
          chk($sformatf("g%0d_cout", g), gc, e[W]);
          chk($sformatf("g%0d_ovf", g), go, e[W+1]);
        end
      end
    end

    initial begin
      logic [W-1:0] ta, tb;
      logic         tc, ts;
      logic [17:0]  m;
      int           w, lat;
      done_g = 1'b0;
      iv = 1'b0; ga = '0; gb = '0; ci = 1'b0; sb = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < NOPS; i++) begin
        ta = W'($urandom); tb = W'($urandom);
        tc = 1'($urandom); ts = 1'($urandom);
        if (g == 4 && i == 0) begin
          ta = W'(8'h99); tb = W'(8'h67); tc = 1'b1; ts = 1'b0;
        end
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        w = 0;
        while (!ir && w < 200) begin
          @(posedge clk); #1;
          w++;
        end
        chk($sformatf("g%0d_ready_wait", g), ir, 1);
        iv = 1'b1; ga = ta; gb = tb; ci = tc; sb = ts;
        @(posedge clk); #1;
        m = model(W, longint'(ta), longint'(tb), tc, ts);
        q.push_back({m[17:16], m[W-1:0]});
        iv = 1'b0; ga = W'($urandom); gb = W'($urandom);
        ci = 1'($urandom); sb = 1'($urandom);
        lat = 0;
        while (!ov && lat < 100) begin
          @(posedge clk); #1;
          lat++;
        end
        chk($sformatf("g%0d_latency", g), lat, N);
      end
      w = 0;
      while (q.size() != 0 && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      chk($sformatf("g%0d_drain", g), q.size(), 0);
      done_g = 1'b1;
    end
  end

  // ---------------- directed sequence and summary ----------------
  initial begin
    int w;
    errors = 0; checks = 0;
    rst0 = 1'b1; rst_r = 1'b1;
    iv0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0; or0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0; rst_r = 1'b0;

    chk("reset_in_ready", ir0, 1);
    chk("reset_out_valid", ov0, 0);
    chk("reset_s", s0, 0);
    chk("reset_cout", co0, 0);
    chk("reset_ovf", of0, 0);

    issue0(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
    issue0(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    issue0(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    issue0(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    issue0(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    issue0(8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b0);

    // Backpressure: result held for 5 cycles, new operands pulsed and ignored.
    or0 = 1'b0;
    issue0(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      iv0 = (k == 1);
      a0 = 8'h55; b0 = 8'h55;
      chk("bp_out_valid", ov0, 1);
      chk("bp_in_ready", ir0, 0);
      chk("bp_s", s0, 8'h80);
      chk("bp_cout", co0, 0);
      chk("bp_ovf", of0, 1);
    end
    iv0 = 1'b0;
    or0 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", {ov0, ir0}, 2'b01);
    @(posedge clk); #1;
    chk("bp_pulse_ignored", {ov0, ir0}, 2'b01);

    // Reset in the middle of RUN discards the operation.
    iv0 = 1'b1; a0 = 8'h0F; b0 = 8'h0F; cin0 = 1'b0; sub0 = 1'b0;
    @(posedge clk); #1;
    iv0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    chk("rst_mid_in_ready", ir0, 1);
    chk("rst_mid_out_valid", ov0, 0);
    chk("rst_mid_s", s0, 0);
    chk("rst_mid_cout", co0, 0);
    issue0(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);

    w = 0;
    while (!(g_cfg[0].done_g && g_cfg[1].done_g && g_cfg[2].done_g &&
             g_cfg[3].done_g && g_cfg[4].done_g) && w < 60000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("random_runs_done", g_cfg[0].done_g && g_cfg[1].done_g && g_cfg[2].done_g &&
        g_cfg[3].done_g && g_cfg[4].done_g, 1);
    chk("d0_drain", q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
